// File: rtl/adc_spi_sequencer_if.sv
// adc_spi_sequencer_if: control, ADC serial pins and result bus of the ADC sequencer.
interface adc_spi_sequencer_if;
   logic        start;
   logic        continuous;
   logic [15:0] period;
   logic        clr_flags;
   logic        SDATA;
   logic        CS;
   logic        SCLK;
   logic        busy;
   logic        sample_valid;
   logic [11:0] sample;
   logic        frame_err;
   logic        overrun;
   modport master (
      output start, continuous, period, clr_flags, SDATA,
      input  CS, SCLK, busy, sample_valid, sample, frame_err, overrun
   );
   modport slave (
      input  start, continuous, period, clr_flags, SDATA,
      output CS, SCLK, busy, sample_valid, sample, frame_err, overrun
   );
endinterface

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: single-clock master for a 16-bit-frame serial ADC; CS/SCLK generation,
// in-domain shift capture, single-shot or timer-periodic triggering with sticky overrun.
module adc_spi_sequencer #(
   parameter int CLK_DIV   = 5,
   parameter int QUIET_CYC = 20
) (
   input logic clk,
   input logic reset,
   adc_spi_sequencer_if.slave bus
);
   localparam int CMAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] QUIET_TC = CW'(QUIET_CYC - 1);
   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TRAIL, QUIET} state_t;
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0] r_bit, w_bit_nxt;
   logic [15:0] r_shift, w_shift_nxt;
   logic [15:0] r_tmr, w_tmr_nxt;
   logic [11:0] r_sample, w_sample_nxt;
   logic r_cs, w_cs_nxt;
   logic r_sclk, w_sclk_nxt;
   logic r_busy, w_busy_nxt;
   logic r_valid, w_valid_nxt;
   logic r_err, w_err_nxt;
   logic r_ovr, w_ovr_nxt;
   logic w_tmr_en, w_fire, w_trig, w_div_tc;
   // Timer fires on zero and reloads period-1, so a new period only lands at the next reload.
   assign w_tmr_en  = bus.continuous && (bus.period != 16'd0);
   assign w_fire    = w_tmr_en && (r_tmr == 16'd0);
   assign w_tmr_nxt = !w_tmr_en ? 16'd0 : w_fire ? bus.period - 16'd1 : r_tmr - 16'd1;
   assign w_trig    = (r_state == IDLE) && (bus.start || w_fire);
   assign w_ovr_nxt = (w_fire && r_state != IDLE) ? 1'b1 : bus.clr_flags ? 1'b0 : r_ovr;
   assign w_div_tc  = r_cnt == DIV_TC;
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt + 1'b1;
      w_bit_nxt    = r_bit;
      w_shift_nxt  = r_shift;
      w_cs_nxt     = r_cs;
      w_sclk_nxt   = r_sclk;
      w_busy_nxt   = r_busy;
      w_valid_nxt  = 1'b0;
      w_sample_nxt = r_sample;
      w_err_nxt    = r_err;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (w_trig) begin
               w_state_nxt = SETUP;
               w_cs_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         SETUP: if (w_div_tc) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            w_sclk_nxt  = 1'b0;
            w_bit_nxt   = 4'd0;
            w_shift_nxt = {r_shift[14:0], bus.SDATA};
         end
         // SDATA is captured on the same edge that drives SCLK low.
         SHIFT: if (w_div_tc) begin
            w_cnt_nxt  = '0;
            w_sclk_nxt = ~r_sclk;
            if (r_sclk) w_shift_nxt = {r_shift[14:0], bus.SDATA};
            else if (r_bit == 4'd15) w_state_nxt = TRAIL;
            else w_bit_nxt = r_bit + 4'd1;
         end
         TRAIL: if (w_div_tc) begin
            w_state_nxt  = QUIET;
            w_cnt_nxt    = '0;
            w_cs_nxt     = 1'b1;
            w_valid_nxt  = 1'b1;
            w_sample_nxt = r_shift[11:0];
            w_err_nxt    = |r_shift[15:12];
         end
         QUIET: if (r_cnt == QUIET_TC) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
         end
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_bit    <= 4'd0;
         r_shift  <= 16'd0;
         r_tmr    <= 16'd0;
         r_cs     <= 1'b1;
         r_sclk   <= 1'b1;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
         r_sample <= 12'd0;
         r_err    <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_bit    <= w_bit_nxt;
         r_shift  <= w_shift_nxt;
         r_tmr    <= w_tmr_nxt;
         r_cs     <= w_cs_nxt;
         r_sclk   <= w_sclk_nxt;
         r_busy   <= w_busy_nxt;
         r_valid  <= w_valid_nxt;
         r_sample <= w_sample_nxt;
         r_err    <= w_err_nxt;
         r_ovr    <= w_ovr_nxt;
      end
   end
   assign bus.CS           = r_cs;
   assign bus.SCLK         = r_sclk;
   assign bus.busy         = r_busy;
   assign bus.sample_valid = r_valid;
   assign bus.sample       = r_sample;
   assign bus.frame_err    = r_err;
   assign bus.overrun      = r_ovr;
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: two sequencers (default timing and CLK_DIV=1/QUIET_CYC=1) driven by a
// serial ADC model and checked every cycle against a frame-timing reference model.
module tb_adc_spi_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   adc_spi_sequencer_if b0();
   adc_spi_sequencer_if b1();
   adc_spi_sequencer #(.CLK_DIV(5), .QUIET_CYC(20)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
   adc_spi_sequencer #(.CLK_DIV(1), .QUIET_CYC(1))  u1 (.clk(clk), .reset(reset), .bus(b1.slave));
   int dv[2] = '{5, 1};
   int qv[2] = '{20, 1};
   bit act[2] = '{0, 0};
   int ft[2] = '{0, 0};
   int c0[2] = '{-1, -1};
   logic [15:0] fw[2] = '{16'd0, 16'd0};
   logic [15:0] nw[2] = '{16'd0, 16'd0};
   bit ramp[2] = '{0, 0};
   bit rnd[2] = '{0, 0};
   logic [11:0] ms[2] = '{12'd0, 12'd0};
   logic me[2] = '{1'b0, 1'b0};
   logic mo[2] = '{1'b0, 1'b0};
   // ADC model: bit index advances on each SCLK fall, rewinds whenever CS is high.
   int idx0 = 0, idx1 = 0;
   always @(negedge b0.SCLK or posedge b0.CS) idx0 <= b0.CS ? 0 : idx0 + 1;
   always @(negedge b1.SCLK or posedge b1.CS) idx1 <= b1.CS ? 0 : idx1 + 1;
   assign b0.SDATA = (idx0 < 16) ? fw[0][4'(15 - idx0)] : 1'b0;
   assign b1.SDATA = (idx1 < 16) ? fw[1][4'(15 - idx1)] : 1'b0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask
   task automatic monitor(input int d, input logic cs, input logic sclk, input logic busy,
                          input logic vld, input logic [11:0] smp, input logic err, input logic ovr,
                          input logic st, input logic cont, input logic [15:0] per, input logic clr);
      int o, dd, qq;
      logic ecs, esclk, ebusy, evld;
      bit fire, idle;
      string p;
      p = (d == 0) ? "u0" : "u1";
      dd = dv[d];
      qq = qv[d];
      if (reset) begin
         act[d] = 0; c0[d] = -1; ms[d] = 12'd0; me[d] = 1'b0; mo[d] = 1'b0;
         chk({p, "_rst_cs"}, 32'(cs), 32'd1);
         chk({p, "_rst_sclk"}, 32'(sclk), 32'd1);
         chk({p, "_rst_busy"}, 32'(busy), 32'd0);
         chk({p, "_rst_valid"}, 32'(vld), 32'd0);
         chk({p, "_rst_sample"}, 32'(smp), 32'd0);
         chk({p, "_rst_ovr"}, 32'(ovr), 32'd0);
         return;
      end
      o = cyc - ft[d] - 1;
      ecs = !(act[d] && o >= 0 && o < 33 * dd);
      esclk = (!ecs && o >= dd && o < 32 * dd) ? (((o - dd) / dd) % 2 == 1) : 1'b1;
      ebusy = act[d] && o >= 0 && o < 33 * dd + qq;
      evld = act[d] && o == 33 * dd;
      if (evld) begin
         ms[d] = fw[d][11:0];
         me[d] = |fw[d][15:12];
      end
      chk({p, "_cs"}, 32'(cs), 32'(ecs));
      chk({p, "_sclk"}, 32'(sclk), 32'(esclk));
      chk({p, "_busy"}, 32'(busy), 32'(ebusy));
      chk({p, "_valid"}, 32'(vld), 32'(evld));
      chk({p, "_sample"}, 32'(smp), 32'(ms[d]));
      chk({p, "_frame_err"}, 32'(err), 32'(me[d]));
      chk({p, "_overrun"}, 32'(ovr), 32'(mo[d]));
      // Periodic trigger: fires every 'per' cycles counted from the first enabled cycle.
      if (!cont || per == 16'd0) c0[d] = -1;
      else if (c0[d] < 0) c0[d] = cyc;
      fire = (c0[d] >= 0) && ((cyc - c0[d]) % int'(per) == 0);
      idle = !act[d] || o >= 33 * dd + qq;
      if (idle && (st || fire)) begin
         act[d] = 1;
         ft[d] = cyc;
         fw[d] = nw[d];
         if (ramp[d]) nw[d] = nw[d] + 16'd1;
         else if (rnd[d]) nw[d] = 16'($urandom);
      end
      if (fire && !idle) mo[d] = 1'b1;
      else if (clr) mo[d] = 1'b0;
   endtask
   always @(negedge clk) begin
      monitor(0, b0.CS, b0.SCLK, b0.busy, b0.sample_valid, b0.sample, b0.frame_err, b0.overrun,
              b0.start, b0.continuous, b0.period, b0.clr_flags);
      monitor(1, b1.CS, b1.SCLK, b1.busy, b1.sample_valid, b1.sample, b1.frame_err, b1.overrun,
              b1.start, b1.continuous, b1.period, b1.clr_flags);
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic pulse0();
      b0.start = 1'b1;
      tick();
      b0.start = 1'b0;
   endtask
   task automatic wait_busy(input logic v, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (b0.busy === v) seen = 1;
         else tick();
      end
      chk("wait_busy", 32'(seen), 32'd1);
   endtask
   initial begin
      logic [15:0] w;
      b0.start = 0; b0.continuous = 0; b0.period = 16'd0; b0.clr_flags = 0;
      b1.start = 0; b1.continuous = 0; b1.period = 16'd0; b1.clr_flags = 0;
      ticks(3);
      reset = 1'b0;
      chk("post_rst_sample", 32'(b0.sample), 32'd0);
      // Single shot 0x0ABC with explicit timing landmarks.
      nw[0] = 16'h0ABC;
      pulse0();
      chk("ss_cs_fall", 32'(b0.CS), 32'd0);
      ticks(165);
      chk("ss_valid_t166", 32'(b0.sample_valid), 32'd1);
      chk("ss_sample", 32'(b0.sample), 32'hABC);
      chk("ss_err", 32'(b0.frame_err), 32'd0);
      ticks(19);
      chk("ss_busy_t185", 32'(b0.busy), 32'd1);
      tick();
      chk("ss_busy_t186", 32'(b0.busy), 32'd0);
      ticks(5);
      nw[0] = 16'h8123;
      pulse0();
      ticks(200);
      chk("err_sample", 32'(b0.sample), 32'h123);
      chk("err_flag", 32'(b0.frame_err), 32'd1);
      chk("err_ovr", 32'(b0.overrun), 32'd0);
      rnd[0] = 1;
      nw[0] = 16'($urandom);
      repeat (3) begin
         pulse0();
         ticks($urandom_range(186, 230));
      end
      rnd[0] = 0;
      // Periodic ramp with stray start pulses while busy.
      nw[0] = 16'($urandom_range(0, 16'hFF00));
      ramp[0] = 1;
      b0.period = 16'd200;
      b0.continuous = 1'b1;
      repeat (4) begin
         wait_busy(1'b0, 400);
         wait_busy(1'b1, 400);
         ticks($urandom_range(1, 150));
         pulse0();
      end
      ticks(250);
      chk("ramp_ovr", 32'(b0.overrun), 32'd0);
      b0.continuous = 1'b0;
      ramp[0] = 0;
      ticks(250);
      // Period shorter than a frame: every other fire is dropped.
      b0.period = 16'd100;
      b0.continuous = 1'b1;
      ticks(650);
      chk("drop_ovr_set", 32'(b0.overrun), 32'd1);
      b0.continuous = 1'b0;
      ticks(250);
      b0.clr_flags = 1'b1;
      tick();
      b0.clr_flags = 1'b0;
      tick();
      chk("drop_ovr_clr", 32'(b0.overrun), 32'd0);
      b0.continuous = 1'b1;
      ticks(300);
      chk("drop_ovr_reset", 32'(b0.overrun), 32'd1);
      b0.continuous = 1'b0;
      ticks(250);
      // Asynchronous reset 80 cycles into a frame.
      nw[0] = 16'h0555;
      pulse0();
      ticks(79);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_cs", 32'(b0.CS), 32'd1);
      chk("mid_rst_sclk", 32'(b0.SCLK), 32'd1);
      chk("mid_rst_busy", 32'(b0.busy), 32'd0);
      chk("mid_rst_sample", 32'(b0.sample), 32'd0);
      ticks(2);
      reset = 1'b0;
      w = 16'($urandom) & 16'h0FFF;
      nw[0] = w;
      pulse0();
      ticks(200);
      chk("post_rst_frame", 32'(b0.sample), 32'(w[11:0]));
      // Fast instance: T+34 valid, T+35 idle, back-to-back accepted.
      nw[1] = 16'h0F0F;
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
      ticks(33);
      chk("fast_valid_t34", 32'(b1.sample_valid), 32'd1);
      chk("fast_sample", 32'(b1.sample), 32'hF0F);
      tick();
      chk("fast_busy_t35", 32'(b1.busy), 32'd0);
      rnd[1] = 1;
      nw[1] = 16'($urandom);
      b1.start = 1'b1;
      tick();
      chk("fast_b2b_cs", 32'(b1.CS), 32'd0);
      ticks(150);
      b1.start = 1'b0;
      ticks(50);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_spi_sequencer.md
Name: adc_spi_sequencer

Overview:
- Master-side sequencer for the 12-bit serial ADC link. Generates CS and SCLK from the system clock, shifts in the 16-bit frame on SDATA, and presents the 12-bit result with a one-cycle valid strobe.
- Conversions start in one of two ways: single-shot on a start pulse, or periodically from an internal sample-rate timer.
- Everything runs in one clk domain, so the rest of the design gets samples without a separate SCLK-clocked receiver.

Parameters:
- CLK_DIV, 5, clk cycles per SCLK half-period (>=1); 100 MHz clk gives 10 MHz SCLK.
- QUIET_CYC, 20, clk cycles CS stays high after a frame before the next conversion may start (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-shot conversion request; sampled only in IDLE.
- continuous  in  1  1 enables periodic conversions.
- period  in  16  sample period in clk cycles; 0 disables the periodic trigger.
- clr_flags  in  1  clears the sticky overrun flag.
- SDATA  in  1  serial data from the ADC, MSB first.
- CS  out  1  ADC chip select, active low, registered.
- SCLK  out  1  serial clock, idles high, registered.
- busy  out  1  high from CS fall until the end of the quiet time.
- sample_valid  out  1  one-clk pulse when sample and frame_err update.
- sample  out  12  last frame bits [11:0].
- frame_err  out  1  last frame's four leading bits [15:12] were not all zero.
- overrun  out  1  sticky; a periodic trigger arrived while not IDLE.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame): CS=1, SCLK=1, busy=0, sample_valid=0, sample=0, frame_err=0, overrun=0, FSM=IDLE, all counters 0.
- States: IDLE, SETUP, SHIFT, TRAIL, QUIET.
- IDLE: CS=1, SCLK=1. A trigger is start=1 or a timer fire in cycle T. On a trigger, go to SETUP; CS=0 and busy=1 from T+1.
- SETUP: hold SCLK high for CLK_DIV cycles, then go to SHIFT.
- SHIFT: generate 16 SCLK periods (low CLK_DIV cycles, then high CLK_DIV cycles).
  - Falling edge k (k=1..16) is at T+1+CLK_DIV+(k-1)*2*CLK_DIV.
  - SDATA is shifted into a 16-bit register (shift left, LSB in) in the same clk cycle that SCLK is driven low, so the first bit is taken at the first falling edge.
  - After the 16th low phase, go to TRAIL.
- TRAIL: SCLK high for CLK_DIV cycles.
- End of TRAIL, at T+1+33*CLK_DIV (T+166 at defaults):
  - CS=1.
  - sample_valid=1 for one cycle.
  - sample=shift[11:0].
  - frame_err=(shift[15:12]!=0).
  - Go to QUIET.
- QUIET: count QUIET_CYC cycles with CS=1, then go to IDLE. busy=0 from T+1+33*CLK_DIV+QUIET_CYC (T+186 at defaults).
- Timer:
  - When continuous=0 or period=0, the timer count is held at 0 and never fires.
  - Otherwise it fires when count==0 and reloads period-1; in all other cycles it decrements.
  - The first fire is therefore the first cycle continuous=1.
  - A change to period takes effect at the next reload.
- Trigger rules:
  - start in any state other than IDLE is ignored and does not set overrun.
  - A timer fire outside IDLE is dropped and sets overrun.
  - start and a timer fire in the same IDLE cycle launch one conversion, with no overrun.
- overrun: sticky. If clr_flags and a new overrun event occur in the same cycle, set wins.
- sample and frame_err hold their values between valid pulses.
- SCLK toggles only while CS=0 and is never glitched: it changes only on counter terminal counts.

Test Plan:
- Single shot, default params, start pulse at T, ADC model drives 0x0ABC -> CS falls at T+1; 16 SCLK falls spaced 10 cycles apart; sample_valid at T+166 with sample=0xABC, frame_err=0; busy=0 at T+186.
- Single shot with frame 0x8123 -> sample=0x123, frame_err=1, overrun=0.
- continuous=1, period=200, ramp data -> sample_valid every 200 cycles; consecutive samples increment; overrun stays 0; start pulses during busy cause no extra frame.
- continuous=1, period=100 -> triggers at +100 are dropped; overrun=1 after the first drop; frames every 200 cycles. Then clr_flags with no coincident drop -> overrun=0, and it sets again on the next drop.
- Reset asserted 80 cycles into a frame -> CS=1, SCLK=1, busy=0 immediately; no sample_valid; sample=0. After release, start yields a correct frame.
- CLK_DIV=1, QUIET_CYC=1 -> frame valid at T+34, busy=0 at T+35; back-to-back start accepted at T+35.
